// File: rtl/level_hs_tx_if.sv
// level_hs_tx_if: local valid/ready, CDC req/ack/data and status signals of level_hs_tx
interface level_hs_tx_if #(
  parameter int NB_DATA  = 8,
  parameter int NB_COUNT = 16
);
  logic                i_valid;
  logic [NB_DATA-1:0]  i_data;
  logic                o_ready;
  logic [NB_DATA-1:0]  o_data;
  logic                o_req;
  logic                i_ack;
  logic                o_done;
  logic [NB_COUNT-1:0] o_xfer_count;
  logic                o_timeout;
  logic                o_ack_err;
  modport master (
    input  i_valid, i_data, i_ack,
    output o_ready, o_data, o_req, o_done, o_xfer_count, o_timeout, o_ack_err
  );
  modport slave (
    output i_valid, i_data, i_ack,
    input  o_ready, o_data, o_req, o_done, o_xfer_count, o_timeout, o_ack_err
  );
endinterface

// File: rtl/level_hs_tx.sv
// level_hs_tx: source-side sender of a 4-phase level req/ack CDC handshake with held data word
module level_hs_tx #(
  parameter int NB_DATA        = 8,
  parameter int NB_COUNT       = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           i_clock,
  input logic           i_reset,
  level_hs_tx_if.master hs
);
  localparam int NB_T = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [NB_T-1:0] T_MAX = NB_T'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_ACK_LO} state_t;
  state_t          state, state_n;
  logic [1:0]      ack_sync;
  logic            ack_s, accept, waiting, hit, done_n;
  logic [NB_T-1:0] t_cnt, t_cnt_n;
  assign ack_s      = ack_sync[1];
  assign hs.o_ready = state == IDLE;
  assign accept     = hs.i_valid && state == IDLE;
  assign waiting    = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        state_n = hs.i_valid ? WAIT_ACK_HI : IDLE;
      WAIT_ACK_HI: state_n = ack_s ? WAIT_ACK_LO : WAIT_ACK_HI;
      WAIT_ACK_LO: state_n = ack_s ? WAIT_ACK_LO : IDLE;
      default:     state_n = IDLE;
    endcase
  end
  // wait-state dwell counter: restarts on any state change, saturates at the limit
  always_comb begin
    t_cnt_n = (state_n != state || !waiting) ? '0 : (t_cnt == T_MAX ? t_cnt : t_cnt + 1'b1);
    hit     = TIMEOUT_CYCLES > 0 && waiting && state_n == state && t_cnt_n == T_MAX;
    done_n  = state == WAIT_ACK_LO && state_n == IDLE;
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      ack_sync        <= '0;
      t_cnt           <= '0;
      hs.o_data       <= '0;
      hs.o_req        <= 1'b0;
      hs.o_done       <= 1'b0;
      hs.o_xfer_count <= '0;
      hs.o_timeout    <= 1'b0;
      hs.o_ack_err    <= 1'b0;
    end else begin
      state           <= state_n;
      ack_sync        <= {ack_sync[0], hs.i_ack};
      t_cnt           <= t_cnt_n;
      hs.o_data       <= accept ? hs.i_data : hs.o_data;
      hs.o_req        <= state_n == WAIT_ACK_HI;
      hs.o_done       <= done_n;
      hs.o_xfer_count <= hs.o_xfer_count + NB_COUNT'(done_n);
      hs.o_timeout    <= hs.o_timeout | hit;
      hs.o_ack_err    <= hs.o_ack_err | (state == IDLE && ack_s);
    end
  end
endmodule

// File: tb/tb_level_hs_tx.sv
// tb_level_hs_tx: directed and random loopback checks of level_hs_tx against a cycle-timeline model
module tb_level_hs_tx;
  localparam int NB_DATA  = 8;
  localparam int NB_COUNT = 2;
  localparam int TMO      = 8;
  localparam int MOD      = 1 << NB_COUNT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop = 1'b1;
  logic ack_drv = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_k = 100;
  logic [7:0] m_data = 8'h00;
  int m_count = 0;
  logic seen;
  level_hs_tx_if #(.NB_DATA(NB_DATA), .NB_COUNT(NB_COUNT)) hs ();
  assign hs.i_ack = loop ? hs.o_req : ack_drv;
  level_hs_tx #(.NB_DATA(NB_DATA), .NB_COUNT(NB_COUNT), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .hs(hs)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // model: m_k = edges since the last accept; a loopback handshake is a fixed 7-cycle timeline
  task automatic step(input logic v, input logic [7:0] d);
    hs.i_valid = v;
    hs.i_data = d;
    @(posedge clk);
    if (m_k >= 6 && v) begin
      m_k = 0;
      m_data = d;
    end else if (m_k < 100) m_k++;
    if (m_k == 6) m_count = (m_count + 1) % MOD;
    #1;
    chk("ready", 32'(hs.o_ready), 32'(m_k >= 6));
    chk("req", 32'(hs.o_req), 32'(m_k <= 2));
    chk("data", 32'(hs.o_data), 32'(m_data));
    chk("done", 32'(hs.o_done), 32'(m_k == 6));
    chk("count", 32'(hs.o_xfer_count), 32'(m_count));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(hs.o_ready), 32'd1);
    chk({tag, "_req"}, 32'(hs.o_req), 32'd0);
    chk({tag, "_data"}, 32'(hs.o_data), 32'd0);
    chk({tag, "_done"}, 32'(hs.o_done), 32'd0);
    chk({tag, "_count"}, 32'(hs.o_xfer_count), 32'd0);
    chk({tag, "_timeout"}, 32'(hs.o_timeout), 32'd0);
    chk({tag, "_ack_err"}, 32'(hs.o_ack_err), 32'd0);
  endtask
  initial begin
    hs.i_valid = 1'b0;
    hs.i_data = 8'h00;
    #12;
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hA5);
    repeat (6) step(1'b0, 8'($urandom));
    chk("single_count", 32'(hs.o_xfer_count), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      step(1'b1, 8'(w));
      repeat (6) step(w < 4, 8'(w + 1));
    end
    chk("b2b_data", 32'(hs.o_data), 32'h04);
    chk("wrap_count", 32'(hs.o_xfer_count), 32'd1);
    repeat (300) step(1'($urandom_range(0, 1)), 8'($urandom));
    repeat (7) step(1'b0, 8'h00);
    chk("rand_timeout", 32'(hs.o_timeout), 32'd0);
    chk("rand_ack_err", 32'(hs.o_ack_err), 32'd0);
    loop = 1'b0;
    ack_drv = 1'b1;
    @(posedge clk);
    #1;
    chk("spur_err_early", 32'(hs.o_ack_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("spur_err", 32'(hs.o_ack_err), 32'd1);
    ack_drv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("spur_done", 32'(hs.o_done), 32'd0);
    end
    chk("spur_count", 32'(hs.o_xfer_count), 32'(m_count));
    chk("spur_ready", 32'(hs.o_ready), 32'd1);
    hs.i_valid = 1'b1;
    hs.i_data = 8'h3C;
    @(posedge clk);
    #1;
    hs.i_valid = 1'b0;
    chk("stall_req", 32'(hs.o_req), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    chk("stall_tmo_early", 32'(hs.o_timeout), 32'd0);
    @(posedge clk);
    #1;
    chk("stall_tmo", 32'(hs.o_timeout), 32'd1);
    ack_drv = 1'b1;
    for (int i = 0; i < 20 && hs.o_req; i++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_req_fall", 32'(hs.o_req), 32'd0);
    ack_drv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = hs.o_done;
    end
    m_count = (m_count + 1) % MOD;
    chk("stall_done", 32'(seen), 32'd1);
    chk("stall_count", 32'(hs.o_xfer_count), 32'(m_count));
    chk("stall_tmo_sticky", 32'(hs.o_timeout), 32'd1);
    chk("stall_data", 32'(hs.o_data), 32'h3C);
    loop = 1'b1;
    hs.i_valid = 1'b1;
    hs.i_data = 8'h5A;
    @(posedge clk);
    #1;
    hs.i_valid = 1'b0;
    chk("mid_req", 32'(hs.o_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    m_k = 100;
    m_data = 8'h00;
    m_count = 0;
    step(1'b0, 8'h00);
    step(1'b1, 8'h11);
    repeat (6) step(1'b0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
